// File: rtl/sad_disparity_scheduler.sv
// sad_disparity_scheduler
// Walks every (column, disparity) pair of one image row through a shared,
// pipelined SAD engine. It keeps the minimum SAD per column and streams the
// winning disparity per column through a 2-entry output FIFO.
// Optional feature macro: SAD_SKIP_INVALID_EN limits each column to the
// disparities whose matching window stays inside the row.
module sad_disparity_scheduler #(
    parameter int IMG_W     = 640,
    parameter int MAX_DISP  = 64,
    parameter int WIN       = 15,
    parameter int DATA_SIZE = 8,
    parameter int SAD_SIZE  = 16,
    parameter int MAX_OUT   = 8,
    parameter int COL_W     = $clog2(IMG_W),
    parameter int DISP_W    = $clog2(MAX_DISP)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  row_start_valid,
    output logic                  row_start_ready,
    output logic                  sad_req_valid,
    input  logic                  sad_req_ready,
    output logic [COL_W-1:0]      sad_req_col,
    output logic [DISP_W-1:0]     sad_req_disp,
    input  logic                  sad_rsp_valid,
    input  logic [SAD_SIZE:0]     sad_rsp_sad,
    output logic                  disp_valid,
    input  logic                  disp_ready,
    output logic [COL_W-1:0]      disp_col,
    output logic [DATA_SIZE-1:0]  disp_value,
    output logic                  row_done,
    output logic                  busy
);

    localparam int HALF  = WIN >> 1;
    localparam int OUT_W = $clog2(MAX_OUT + 1);

`ifdef SAD_SKIP_INVALID_EN
    localparam bit SKIP_EN = 1'b1;
`else
    localparam bit SKIP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    // Highest disparity searched for a column (clipped to the row when skipping).
    function automatic logic [DISP_W-1:0] disp_limit(input logic [COL_W-1:0] col);
        int v;
        v = int'(col) - HALF;
        if (!SKIP_EN || v > MAX_DISP - 1)
            v = MAX_DISP - 1;
        if (v < 0)
            v = 0;
        return DISP_W'(v);
    endfunction

    state_t               state_reg, state_next;
    logic [COL_W-1:0]     req_col_reg;
    logic [DISP_W-1:0]    req_disp_reg;
    logic [OUT_W-1:0]     out_cnt_reg;
    logic [1:0]           cif_reg;
    logic [COL_W-1:0]     rsp_col_reg;
    logic [DISP_W-1:0]    rsp_disp_reg;
    logic [SAD_SIZE:0]    min_sad_reg, min_sad_next;
    logic [DISP_W-1:0]    best_reg, best_next;
    logic                 wr_ptr_reg, rd_ptr_reg;
    logic [1:0]           cnt_reg;

    logic room, credit, req_fire, req_last_disp, req_last_col;
    logic rsp_take, push, pop;

    // A response with nothing outstanding is a protocol error and is dropped.
    assign rsp_take      = sad_rsp_valid && (out_cnt_reg != '0);
    assign req_last_disp = (req_disp_reg == disp_limit(req_col_reg));
    assign req_last_col  = (req_col_reg == COL_W'(IMG_W - 1));
    assign room          = (out_cnt_reg < OUT_W'(MAX_OUT)) ||
                           ((out_cnt_reg == OUT_W'(MAX_OUT)) && sad_rsp_valid);
    // A new column may start only if at most one column result is pending
    // anywhere (in flight or buffered), so the 2-entry FIFO can never overflow.
    assign credit        = (req_disp_reg != '0) ||
                           (({1'b0, cif_reg} + {1'b0, cnt_reg}) < 3'd2);
    assign sad_req_valid = (state_reg == ISSUE) && room && credit;
    assign req_fire      = sad_req_valid && sad_req_ready;
    assign push          = rsp_take && (rsp_disp_reg == disp_limit(rsp_col_reg));
    assign pop           = disp_valid && disp_ready;

    assign row_start_ready = (state_reg == IDLE);
    assign busy            = (state_reg != IDLE);
    assign row_done        = (state_reg == DONE);
    assign sad_req_col     = req_col_reg;
    assign sad_req_disp    = req_disp_reg;
    assign disp_valid      = (cnt_reg != 2'd0);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    // Next-state logic for the row sequence.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:  if (row_start_valid) state_next = ISSUE;
            ISSUE: if (req_fire && req_last_col && req_last_disp) state_next = DRAIN;
            DRAIN: if ((out_cnt_reg == '0) && (cif_reg == 2'd0) &&
                       (cnt_reg == 2'd0) && !sad_rsp_valid)
                       state_next = DONE;
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request cursor: column-major, disparity ascending; wraps to (0,0) after the row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_col_reg  <= '0;
            req_disp_reg <= '0;
        end else if (req_fire) begin
            if (req_last_disp) begin
                req_disp_reg <= '0;
                req_col_reg  <= req_last_col ? '0 : req_col_reg + 1'b1;
            end else begin
                req_disp_reg <= req_disp_reg + 1'b1;
            end
        end
    end

    // Outstanding-request and columns-in-flight bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_cnt_reg <= '0;
            cif_reg     <= 2'd0;
        end else begin
            case ({req_fire, rsp_take})
                2'b10:   out_cnt_reg <= out_cnt_reg + 1'b1;
                2'b01:   out_cnt_reg <= out_cnt_reg - 1'b1;
                default: out_cnt_reg <= out_cnt_reg;
            endcase
            case ({req_fire && (req_disp_reg == '0), push})
                2'b10:   cif_reg <= cif_reg + 1'b1;
                2'b01:   cif_reg <= cif_reg - 1'b1;
                default: cif_reg <= cif_reg;
            endcase
        end
    end

    // Running minimum; strict less-than keeps the lowest disparity on ties.
    always_comb begin
        min_sad_next = min_sad_reg;
        best_next    = best_reg;
        if (rsp_take && ((rsp_disp_reg == '0) || (sad_rsp_sad < min_sad_reg))) begin
            min_sad_next = sad_rsp_sad;
            best_next    = rsp_disp_reg;
        end
    end

    // Response cursor and accumulator registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_col_reg  <= '0;
            rsp_disp_reg <= '0;
            min_sad_reg  <= '0;
            best_reg     <= '0;
        end else if (rsp_take) begin
            min_sad_reg <= min_sad_next;
            best_reg    <= best_next;
            if (push) begin
                rsp_disp_reg <= '0;
                rsp_col_reg  <= (rsp_col_reg == COL_W'(IMG_W - 1)) ? '0 : rsp_col_reg + 1'b1;
            end else begin
                rsp_disp_reg <= rsp_disp_reg + 1'b1;
            end
        end
    end

    // Output FIFO storage, one register pair per entry.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ent
            logic [COL_W-1:0]  col_reg;
            logic [DISP_W-1:0] disp_reg;
            // Capture a finished column into this slot when the write pointer selects it.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    col_reg  <= '0;
                    disp_reg <= '0;
                end else if (push && (int'(wr_ptr_reg) == gi)) begin
                    col_reg  <= rsp_col_reg;
                    disp_reg <= best_next;
                end
            end
        end
    endgenerate

    assign disp_col   = rd_ptr_reg ? g_ent[1].col_reg : g_ent[0].col_reg;
    assign disp_value = DATA_SIZE'(rd_ptr_reg ? g_ent[1].disp_reg : g_ent[0].disp_reg);

    // FIFO pointers and occupancy; simultaneous push and pop keep the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            cnt_reg    <= 2'd0;
        end else begin
            if (push)
                wr_ptr_reg <= ~wr_ptr_reg;
            if (pop)
                rd_ptr_reg <= ~rd_ptr_reg;
            case ({push, pop})
                2'b10:   cnt_reg <= cnt_reg + 1'b1;
                2'b01:   cnt_reg <= cnt_reg - 1'b1;
                default: cnt_reg <= cnt_reg;
            endcase
        end
    end

endmodule

// File: tb/tb_sad_disparity_scheduler.sv
// Bench for sad_disparity_scheduler: randomized engine latency/backpressure
// against a queue-based reference model of requests and per-column argmin.
module tb_sad_disparity_scheduler;

`ifdef SAD_SKIP_INVALID_EN
    localparam int IMG_W     = 12;
    localparam int TGT_COL   = 4;
    localparam int EXP_TOTAL = 36;
`else
    localparam int IMG_W     = 4;
    localparam int TGT_COL   = 1;
    localparam int EXP_TOTAL = 16;
`endif
    localparam int MAX_DISP  = 4;
    localparam int WIN       = 5;
    localparam int HALF      = WIN >> 1;
    localparam int DATA_SIZE = 8;
    localparam int SAD_SIZE  = 16;
    localparam int MAX_OUT   = 8;
    localparam int COL_W     = $clog2(IMG_W);
    localparam int DISP_W    = $clog2(MAX_DISP);

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 row_start_valid;
    logic                 row_start_ready;
    logic                 sad_req_valid;
    logic                 sad_req_ready;
    logic [COL_W-1:0]     sad_req_col;
    logic [DISP_W-1:0]    sad_req_disp;
    logic                 sad_rsp_valid;
    logic [SAD_SIZE:0]    sad_rsp_sad;
    logic                 disp_valid;
    logic                 disp_ready;
    logic [COL_W-1:0]     disp_col;
    logic [DATA_SIZE-1:0] disp_value;
    logic                 row_done;
    logic                 busy;

    sad_disparity_scheduler #(
        .IMG_W(IMG_W), .MAX_DISP(MAX_DISP), .WIN(WIN), .DATA_SIZE(DATA_SIZE),
        .SAD_SIZE(SAD_SIZE), .MAX_OUT(MAX_OUT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .row_start_valid(row_start_valid), .row_start_ready(row_start_ready),
        .sad_req_valid(sad_req_valid), .sad_req_ready(sad_req_ready),
        .sad_req_col(sad_req_col), .sad_req_disp(sad_req_disp),
        .sad_rsp_valid(sad_rsp_valid), .sad_rsp_sad(sad_rsp_sad),
        .disp_valid(disp_valid), .disp_ready(disp_ready),
        .disp_col(disp_col), .disp_value(disp_value),
        .row_done(row_done), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    typedef struct {int col; int disp;} req_t;
    typedef struct {int col; int disp; int due;} eng_t;

    int unsigned sad_tab [IMG_W][MAX_DISP];
    int  mode, lat, rdy_mode, drdy_mode;
    int  cyc = 0;
    req_t exp_req[$];
    req_t rsp_track[$];
    int  exp_res_col[$];
    int  exp_res_val[$];
    int  got_val[$];
    int  req_seen, done_pulses, model_out, model_occ, max_out_seen;
    bit  in_row = 1'b0;
    bit  expect_valid_next = 1'b0;
    bit  saw_tgt = 1'b0;

    // Number of disparities searched for a column, minus one.
    function automatic int model_lim(input int c);
`ifdef SAD_SKIP_INVALID_EN
        int v;
        v = c - HALF;
        if (v < 0) v = 0;
        if (v > MAX_DISP - 1) v = MAX_DISP - 1;
        return v;
`else
        return MAX_DISP - 1 + 0 * c;
`endif
    endfunction

    // Hand-worked result for the |d-2|*10 pattern.
    function automatic int lit_val(input int c);
`ifdef SAD_SKIP_INVALID_EN
        if (c <= 2) return 0;
        if (c == 3) return 1;
        return 2;
`else
        return 2 + 0 * c;
`endif
    endfunction

    // Fill the SAD table for the chosen pattern and derive the expected streams.
    task automatic build_row();
        exp_req.delete();
        exp_res_col.delete();
        exp_res_val.delete();
        got_val.delete();
        req_seen = 0;
        done_pulses = 0;
        max_out_seen = 0;
        for (int c = 0; c < IMG_W; c++) begin
            int best;
            int unsigned m;
            for (int d = 0; d < MAX_DISP; d++) begin
                case (mode)
                    0: sad_tab[c][d] = (d >= 2) ? (d - 2) * 10 : (2 - d) * 10;
                    1: sad_tab[c][d] = 7;
                    2: sad_tab[c][d] = $urandom_range(0, 5);
                    default: sad_tab[c][d] = $urandom_range(0, 131071);
                endcase
            end
            best = 0;
            m = sad_tab[c][0];
            for (int d = 0; d <= model_lim(c); d++) begin
                exp_req.push_back('{c, d});
                if (sad_tab[c][d] < m) begin
                    m = sad_tab[c][d];
                    best = d;
                end
            end
            exp_res_col.push_back(c);
            exp_res_val.push_back(best);
        end
    endtask

    // Engine and downstream model: in-order responses after 'lat' cycles.
    initial begin
        eng_t eng_q[$];
        bit f_req, f_rsp;
        int rc, rd;
        sad_req_ready = 1'b0;
        sad_rsp_valid = 1'b0;
        sad_rsp_sad   = '0;
        disp_ready    = 1'b0;
        forever begin
            @(negedge clk);
            f_req = sad_req_valid && sad_req_ready;
            f_rsp = sad_rsp_valid;
            rc = int'(sad_req_col);
            rd = int'(sad_req_disp);
            @(posedge clk);
            #1;
            cyc++;
            if (!rst_n) begin
                eng_q.delete();
                sad_rsp_valid = 1'b0;
                sad_req_ready = 1'b0;
                disp_ready    = 1'b0;
            end else begin
                if (f_rsp && eng_q.size() > 0) void'(eng_q.pop_front());
                if (f_req) eng_q.push_back('{rc, rd, cyc + lat - 1});
                sad_rsp_valid = (eng_q.size() > 0) && (eng_q[0].due <= cyc);
                sad_rsp_sad   = (eng_q.size() > 0) ?
                                (SAD_SIZE+1)'(sad_tab[eng_q[0].col][eng_q[0].disp]) : '0;
                sad_req_ready = rdy_mode ? 1'($urandom_range(0, 1)) : 1'b1;
                disp_ready    = (drdy_mode == 0) ? 1'b1 :
                                (drdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            end
        end
    end

    // Compare process: checks every handshake and status bit each cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_req.delete();
                exp_res_col.delete();
                exp_res_val.delete();
                rsp_track.delete();
                model_out = 0;
                model_occ = 0;
                in_row = 1'b0;
                expect_valid_next = 1'b0;
            end else begin
                bit pop_now;
                check("busy", 32'(busy), 32'(in_row));
                check("row_start_ready", 32'(row_start_ready), 32'(!in_row));
                if (expect_valid_next)
                    check("disp_latency", 32'(disp_valid), 1);
                expect_valid_next = 1'b0;
                if (row_done) done_pulses++;
                if (in_row && model_out == MAX_OUT && !sad_rsp_valid)
                    check("cap_stall", 32'(sad_req_valid), 0);
                pop_now = disp_valid && disp_ready;
                if (sad_rsp_valid) begin
                    if (model_out == 0 || rsp_track.size() == 0) begin
                        check("rsp_protocol", 0, 1);
                    end else begin
                        req_t r;
                        model_out--;
                        r = rsp_track.pop_front();
                        if (r.disp == model_lim(r.col)) begin
                            check("fifo_room", 32'((model_occ - int'(pop_now)) < 2), 1);
                            if (model_occ == 0) expect_valid_next = 1'b1;
                            model_occ++;
                        end
                    end
                end
                if (sad_req_valid && sad_req_ready) begin
                    if (exp_req.size() == 0) begin
                        check("extra_req", 1, 0);
                    end else begin
                        req_t e;
                        e = exp_req.pop_front();
                        check("req_col", 32'(sad_req_col), 32'(e.col));
                        check("req_disp", 32'(sad_req_disp), 32'(e.disp));
                        rsp_track.push_back(e);
                    end
                    req_seen++;
                    model_out++;
                    if (model_out > max_out_seen) max_out_seen = model_out;
                    check("outstanding_le_max", 32'(model_out <= MAX_OUT), 1);
                    if (int'(sad_req_col) == TGT_COL && int'(sad_req_disp) == 2) saw_tgt = 1'b1;
                end
                if (pop_now) begin
                    if (exp_res_col.size() == 0) begin
                        check("extra_result", 1, 0);
                    end else begin
                        check("disp_col", 32'(disp_col), 32'(exp_res_col.pop_front()));
                        check("disp_value", 32'(disp_value), 32'(exp_res_val[0]));
                        void'(exp_res_val.pop_front());
                    end
                    got_val.push_back(int'(disp_value));
                    model_occ--;
                end
                if (row_start_valid && row_start_ready) in_row = 1'b1;
                if (row_done) in_row = 1'b0;
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_valid"}, 32'(sad_req_valid), 0);
        check({tag, "_disp_valid"}, 32'(disp_valid), 0);
        check({tag, "_row_done"}, 32'(row_done), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_start_ready"}, 32'(row_start_ready), 1);
        check({tag, "_req_col"}, 32'(sad_req_col), 0);
        check({tag, "_req_disp"}, 32'(sad_req_disp), 0);
        check({tag, "_disp_col"}, 32'(disp_col), 0);
        check({tag, "_disp_value"}, 32'(disp_value), 0);
    endtask

    task automatic start_row(input int hold_extra);
        bit ok;
        build_row();
        @(posedge clk);
        #1;
        row_start_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = row_start_ready;
            @(posedge clk);
            #1;
        end
        repeat (hold_extra) @(posedge clk);
        #1;
        row_start_valid = 1'b0;
        if (!ok) check("row_start_accept", 0, 1);
    endtask

    task automatic wait_done(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 4000 && !seen; i++) begin
            @(negedge clk);
            seen = row_done;
        end
        if (!seen) check({tag, "_timeout"}, 0, 1);
        @(negedge clk);
        check({tag, "_busy_after"}, 32'(busy), 0);
        check({tag, "_done_pulses"}, 32'(done_pulses), 1);
        check({tag, "_req_total"}, 32'(req_seen), EXP_TOTAL);
        check({tag, "_req_left"}, 32'(exp_req.size()), 0);
        check({tag, "_res_left"}, 32'(exp_res_col.size()), 0);
        $display("row %s: %0d requests, %0d results, max outstanding %0d",
                 tag, req_seen, got_val.size(), max_out_seen);
    endtask

    initial begin
        row_start_valid = 1'b0;
        mode = 0; lat = 1; rdy_mode = 0; drdy_mode = 0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // |d-2|*10 pattern, single-cycle engine, no backpressure.
        mode = 0; lat = 1; rdy_mode = 0; drdy_mode = 0;
        start_row(0);
        wait_done("vshape");
        check("vshape_nres", 32'(got_val.size()), IMG_W);
        for (int c = 0; c < IMG_W && c < got_val.size(); c++)
            check("vshape_lit", 32'(got_val[c]), 32'(lit_val(c)));

        // All-equal SAD: lowest disparity wins.
        mode = 1;
        start_row(0);
        wait_done("tie");
        for (int c = 0; c < IMG_W && c < got_val.size(); c++)
            check("tie_lit", 32'(got_val[c]), 0);

        // Long engine latency fills the outstanding window.
        mode = 2; lat = 20;
        start_row(0);
        wait_done("lat20");
        check("lat20_max_out", 32'(max_out_seen), MAX_OUT);

        // Downstream stalled: issue must park at disparity 0 of column 2.
        mode = 3; lat = 2; drdy_mode = 2;
        start_row(0);
        repeat (80) @(negedge clk);
        check("stall_req_valid", 32'(sad_req_valid), 0);
        check("stall_req_col", 32'(sad_req_col), 2);
        check("stall_req_disp", 32'(sad_req_disp), 0);
        check("stall_disp_valid", 32'(disp_valid), 1);
        check("stall_disp_col", 32'(disp_col), 0);
        drdy_mode = 0;
        wait_done("stall");

        // Asynchronous reset in the middle of issuing.
        mode = 2; lat = 3; rdy_mode = 0; drdy_mode = 0;
        saw_tgt = 1'b0;
        start_row(0);
        for (int i = 0; i < 500 && !saw_tgt; i++) @(negedge clk);
        check("reset_target_reached", 32'(saw_tgt), 1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        start_row(0);
        wait_done("after_reset");

        // Randomized rows: latency, engine ready and downstream ready all vary.
        for (int r = 0; r < 6; r++) begin
            mode = 2 + (r % 2);
            lat = $urandom_range(1, 8);
            rdy_mode = 1;
            drdy_mode = 1;
            start_row($urandom_range(0, 4));
            wait_done($sformatf("rand%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sad_disparity_scheduler.md
Name: sad_disparity_scheduler

Overview:
- Sequences a shared, pipelined SAD engine across every (column, disparity) pair of one image row.
- Tracks the minimum SAD per column and emits the winning disparity as a stream to the depth-map writer.
- Sits between the row-block buffer (which signals a WIN-row block is ready) and the output row assembler.

Parameters:
IMG_W, 640, pixels per row; columns processed 0..IMG_W-1
MAX_DISP, 64, disparities searched per column, 0..MAX_DISP-1
WIN, 15, window size; HALF = WIN>>1 (used only by the optional feature)
DATA_SIZE, 8, width of the disp_value output
SAD_SIZE, 16, SAD result width is SAD_SIZE+1 bits
MAX_OUT, 8, maximum SAD requests outstanding (issued but no response yet)
COL_W, $clog2(IMG_W), column index width
DISP_W, $clog2(MAX_DISP), disparity index width

Ports:
clk  in  1  clock, all logic rising-edge
rst_n  in  1  asynchronous active-low reset
row_start_valid  in  1  WIN-row block ready for processing
row_start_ready  out  1  high only in IDLE; row starts on valid&&ready
sad_req_valid  out  1  request to SAD engine
sad_req_ready  in  1  engine accepts request
sad_req_col  out  COL_W  column of request
sad_req_disp  out  DISP_W  disparity of request
sad_rsp_valid  in  1  one in-order response, no backpressure
sad_rsp_sad  in  SAD_SIZE+1  SAD value
disp_valid  out  1  best-disparity result available
disp_ready  in  1  downstream accepts result
disp_col  out  COL_W  column of result
disp_value  out  DATA_SIZE  best disparity, zero-extended
row_done  out  1  one-cycle pulse, row complete
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst_n low): state IDLE; all counters cleared; output FIFO emptied. sad_req_valid=0, disp_valid=0, row_done=0, busy=0, row_start_ready=1 (combinational from IDLE), sad_req_col/disp=0, disp_col/value=0. Reset mid-row discards all in-flight work; responses arriving after reset release are ignored for the first MAX_OUT cycles is NOT required — the engine is reset on the same rst_n.
- States:
  - IDLE -> ISSUE on row_start_valid&&row_start_ready.
  - ISSUE -> DRAIN after the request for (IMG_W-1, last disparity) is accepted.
  - DRAIN -> DONE when outstanding==0, columns in flight==0, FIFO empty and no handshake is pending.
  - DONE -> IDLE after 1 cycle; row_done=1 in DONE only.
- Issue order: column-major, disparity ascending. One request per cycle maximum. Request fields are held stable while valid&&!ready.
- sad_req_valid is high in ISSUE only when all three hold:
  - outstanding < MAX_OUT (or == MAX_OUT with a response arriving this cycle);
  - issuing disparity 0 of a new column is permitted only if (columns in flight + FIFO occupancy) < 2;
  - continuing within a column is always permitted.
- Outstanding counter: +1 on a request handshake, -1 on sad_rsp_valid. A simultaneous request and response leaves it unchanged. A response with outstanding==0 is a protocol error; the bench asserts on it, and the RTL saturates at 0.
- Response accumulator:
  - First response of a column loads min_sad=value, best=0.
  - Later responses replace min_sad/best only if value < min_sad (strict less-than). Ties keep the lower disparity.
  - The last response of a column pushes {col, best} into the 2-entry output FIFO in the same cycle. Space is guaranteed by the credit rule. If both FIFO entries are occupied at push time, that is an internal error and the bench asserts on it.
- Output FIFO: 2 entries; head drives disp_col/disp_value/disp_valid; pop on disp_valid&&disp_ready. A push and a pop in the same cycle are both allowed. Latency is 1 cycle from the last response to disp_valid when the FIFO is empty.
- Column ordering is preserved on the output stream.
- row_start_valid is ignored outside IDLE.

Optional Feature:
SAD_SKIP_INVALID_EN
- Defined: for column c, only disparities 0..min(MAX_DISP-1, max(c-HALF,0)) are requested. Column-done detection uses this per-column limit. Columns 0..HALF request disparity 0 only. Fewer total cycles.
- Undefined: every column requests all MAX_DISP disparities. Total requests = IMG_W*MAX_DISP.

Test Plan:
- IMG_W=4, MAX_DISP=4, zero-latency engine with ready=1 and SAD=|d-2|*10 for all columns -> 16 requests in order (0,0)..(3,3); 4 results with disp_value=2, cols 0..3; a single row_done pulse; busy low afterwards.
- Tie case, SAD=7 for all d -> every disp_value=0 (lowest index wins).
- Engine latency 20, MAX_OUT=8 -> outstanding never exceeds 8; sad_req_valid drops while 8 are outstanding; results are correct and in order.
- disp_ready held low -> request issue stalls at disparity 0 of the 3rd column (2 results buffered). Releasing ready drains cols 0,1, then issue resumes with no loss or duplication.
- rst_n pulsed low mid-ISSUE (col 1, d 2) -> all outputs return to reset values immediately. A new row_start afterwards processes the full row from (0,0).
- SAD_SKIP_INVALID_EN, IMG_W=12, MAX_DISP=4, WIN=5 (HALF=2) -> cols 0-2 issue d=0 only, col 3 issues d 0..1, col 4 issues d 0..2, cols 5-11 issue d 0..3; total requests 3+2+3+28=36.
